// File: rtl/layer_sequencer.sv
// Layer sequencer: drives the MAC step counter, accumulator clear and capture strobes
// for every layer of the neuron network, then holds the final result until accepted.
module layer_sequencer #(
  parameter int unsigned NEURON_WIDTH = 3,
  parameter int unsigned COUNTER_END  = 6,
  parameter int unsigned NUM_LAYERS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        in_ready,
  input  logic        abort,
  output logic        busy,
  output logic [31:0] counter,
  output logic        acc_clr,
  output logic        mac_en,
  output logic        activation_function,
  output logic [3:0]  layer_idx,
  output logic        capture,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAC,
    S_DRAIN,
    S_ACT,
    S_OUT
  } state_e;

  localparam logic [31:0] MAC_LAST   = 32'(NEURON_WIDTH);
  localparam logic [31:0] CNT_LAST   = 32'(COUNTER_END);
  localparam logic [3:0]  LAYER_LAST = 4'(NUM_LAYERS - 1);

  if (COUNTER_END < NEURON_WIDTH + 1) begin : g_bad_counter_end
    $error("layer_sequencer: COUNTER_END must be >= NEURON_WIDTH+1");
  end
  if (NUM_LAYERS < 1 || NUM_LAYERS > 16) begin : g_bad_num_layers
    $error("layer_sequencer: NUM_LAYERS must be in 1..16");
  end

  state_e      state_q;
  logic [31:0] counter_q;
  logic [3:0]  layer_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        acc_clr_q;
  logic        mac_en_q;
  logic        act_q;
  logic        capture_q;
  logic        out_valid_q;
  logic [3:0]  layer_d;
  logic [31:0] counter_d;

  assign layer_d   = layer_q + 4'd1;
  assign counter_d = counter_q + 32'd1;

  always_ff @(posedge clk) begin
    // abort drops everything back to the reset state, so it shares the reset path
    if (rst || (abort && state_q != S_IDLE)) begin
      state_q     <= S_IDLE;
      counter_q   <= '0;
      layer_q     <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      acc_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      act_q       <= 1'b0;
      capture_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_clr_q <= 1'b0;
      capture_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          counter_q <= '0;
          if (start) begin
            state_q    <= S_CLR;
            layer_q    <= '0;
            act_q      <= (LAYER_LAST != 4'd0);
            acc_clr_q  <= 1'b1;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        S_CLR: begin
          state_q   <= S_MAC;
          counter_q <= '0;
          mac_en_q  <= 1'b1;
        end
        S_MAC: begin
          counter_q <= counter_d;
          if (counter_q == MAC_LAST) begin
            state_q  <= S_DRAIN;
            mac_en_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (counter_q == CNT_LAST) begin
            state_q   <= S_ACT;
            capture_q <= 1'b1;
          end else begin
            counter_q <= counter_d;
          end
        end
        S_ACT: begin
          counter_q <= '0;
          if (layer_q != LAYER_LAST) begin
            state_q   <= S_CLR;
            layer_q   <= layer_d;
            act_q     <= (layer_d != LAYER_LAST);
            acc_clr_q <= 1'b1;
          end else begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
          end
        end
        S_OUT: begin
          counter_q <= '0;
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready            = in_ready_q;
  assign busy                = busy_q;
  assign counter             = counter_q;
  assign acc_clr             = acc_clr_q;
  assign mac_en              = mac_en_q;
  assign activation_function = act_q;
  assign layer_idx           = layer_q;
  assign capture             = capture_q;
  assign out_valid           = out_valid_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: scoreboard of expected capture/out_valid events plus
// cycle-by-cycle trace checks, backpressure, abort, reset and a minimal-size instance.
module tb_layer_sequencer;

  localparam int unsigned NW  = 3;
  localparam int unsigned CE  = 6;
  localparam int unsigned NL  = 2;
  localparam int unsigned LAT = CE + 3;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic        in_ready, busy, acc_clr, mac_en, act, capture, out_valid;
  logic [31:0] counter;
  logic [3:0]  layer_idx;

  logic        b_start, b_abort, b_out_ready;
  logic        b_in_ready, b_busy, b_acc_clr, b_mac_en, b_act, b_capture, b_out_valid;
  logic [31:0] b_counter;
  logic [3:0]  b_layer_idx;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  typedef struct {
    logic        is_out;
    int unsigned cyc;
    logic [3:0]  layer;
    logic        act;
  } ev_t;

  ev_t sb_q[$];

  layer_sequencer #(.NEURON_WIDTH(NW), .COUNTER_END(CE), .NUM_LAYERS(NL)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .abort(abort),
    .busy(busy), .counter(counter), .acc_clr(acc_clr), .mac_en(mac_en),
    .activation_function(act), .layer_idx(layer_idx), .capture(capture),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  layer_sequencer #(.NEURON_WIDTH(0), .COUNTER_END(1), .NUM_LAYERS(1)) dut_min (
    .clk(clk), .rst(rst), .start(b_start), .in_ready(b_in_ready), .abort(b_abort),
    .busy(b_busy), .counter(b_counter), .acc_clr(b_acc_clr), .mac_en(b_mac_en),
    .activation_function(b_act), .layer_idx(b_layer_idx), .capture(b_capture),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected per-cycle trace of one default-size run, n = cycles after the start edge.
  function automatic void exp_trace(input int unsigned n, output logic [31:0] cnt,
                                    output logic mac, output logic clr,
                                    output logic a, output logic cap);
    int unsigned p, l;
    cnt = '0; mac = 1'b0; clr = 1'b0; a = 1'b0; cap = 1'b0;
    if (n >= 1 && n <= LAT * NL) begin
      p   = (n - 1) % LAT;
      l   = (n - 1) / LAT;
      a   = (l != NL - 1);
      clr = (p == 0);
      cap = (p == LAT - 1);
      mac = (p >= 1 && p <= NW + 1);
      if (p == 0)           cnt = '0;
      else if (p <= CE + 1) cnt = 32'(p - 1);
      else                  cnt = 32'(CE);
    end
  endfunction

  // Drives a one-cycle start and books the events the run must produce; returns at +1.
  task automatic do_start(output int unsigned c);
    ev_t e;
    c = cyc;
    start = 1'b1;
    for (int unsigned l = 0; l < NL; l++) begin
      e.is_out = 1'b0;
      e.cyc    = c + LAT * (l + 1);
      e.layer  = 4'(l);
      e.act    = (l != NL - 1);
      sb_q.push_back(e);
    end
    e.is_out = 1'b1;
    e.cyc    = c + LAT * NL + 1;
    e.layer  = 4'(NL - 1);
    e.act    = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (capture || (out_valid && !ov_prev)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_strobe", {30'd0, capture, out_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_kind", {31'd0, out_valid}, {31'd0, e.is_out});
        check("sb_cycle", cyc, e.cyc);
        check("sb_layer", {28'd0, layer_idx}, {28'd0, e.layer});
        check("sb_strobe_excl", {31'd0, capture & out_valid}, 32'd0);
        if (!e.is_out) check("sb_act", {31'd0, act}, {31'd0, e.act});
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    logic [31:0] ec;
    logic em, eclr, eact, ecap, seen;

    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    b_start = 1'b0; b_abort = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_counter", counter, 32'd0);
    check("rst_strobes", {28'd0, acc_clr, mac_en, capture, out_valid}, 32'd0);
    check("rst_layer_act", {27'd0, layer_idx, act}, 32'd0);
    check("rst_min_in_ready", {31'd0, b_in_ready}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full default run with per-cycle trace, then backpressure in OUT
    do_start(c);
    for (int unsigned n = 1; n <= LAT * NL + 1; n++) begin
      exp_trace(n, ec, em, eclr, eact, ecap);
      check("trace_counter", counter, ec);
      check("trace_mac_en", {31'd0, mac_en}, {31'd0, em});
      check("trace_acc_clr", {31'd0, acc_clr}, {31'd0, eclr});
      check("trace_capture", {31'd0, capture}, {31'd0, ecap});
      check("trace_act", {31'd0, act}, {31'd0, eact});
      check("trace_busy", {31'd0, busy}, 32'd1);
      if (n < LAT * NL + 1) @(negedge clk);
    end
    check("run1_out_valid", {31'd0, out_valid}, 32'd1);
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_layer", {28'd0, layer_idx}, 32'd1);
      check("bp_no_restart", {31'd0, acc_clr}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    check("hs_in_ready", {31'd0, in_ready}, 32'd1);
    check("hs_busy", {31'd0, busy}, 32'd0);
    check("hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("hs_start_ignored", {31'd0, acc_clr}, 32'd0);
    repeat (3) @(negedge clk);

    // Abort in DRAIN of layer 0
    do_start(c);
    repeat (5) @(negedge clk);
    check("ab_pre_counter", counter, 32'd4);
    check("ab_pre_mac_en", {31'd0, mac_en}, 32'd0);
    abort = 1'b1;
    sb_q.delete();
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_in_ready", {31'd0, in_ready}, 32'd1);
    check("ab_counter", counter, 32'd0);
    check("ab_strobes", {29'd0, acc_clr, mac_en, capture}, 32'd0);
    repeat (25) @(negedge clk);

    // Restart after abort completes normally
    do_start(c);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int unsigned i = 0; i < 40 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("run2_out_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check("run2_idle", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);

    // rst mid-MAC of layer 1, then rst together with abort
    for (int unsigned k = 0; k < 2; k++) begin
      do_start(c);
      repeat (11) @(negedge clk);
      check("rm_pre_layer", {28'd0, layer_idx}, 32'd1);
      check("rm_pre_mac", {31'd0, mac_en}, 32'd1);
      check("rm_pre_counter", counter, 32'd1);
      rst = 1'b1;
      abort = (k == 1);
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      abort = 1'b0;
      check("rm_layer", {28'd0, layer_idx}, 32'd0);
      check("rm_busy", {31'd0, busy}, 32'd0);
      check("rm_in_ready", {31'd0, in_ready}, 32'd1);
      check("rm_counter", counter, 32'd0);
      check("rm_act_mac", {30'd0, act, mac_en}, 32'd0);
      repeat (25) @(negedge clk);
    end

    // Minimal instance: NEURON_WIDTH=0, COUNTER_END=1, NUM_LAYERS=1
    b_out_ready = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    check("min_p1_acc_clr", {31'd0, b_acc_clr}, 32'd1);
    check("min_p1_act", {31'd0, b_act}, 32'd0);
    @(negedge clk);
    check("min_p2_mac", {31'd0, b_mac_en}, 32'd1);
    check("min_p2_counter", b_counter, 32'd0);
    @(negedge clk);
    check("min_p3_mac", {31'd0, b_mac_en}, 32'd0);
    check("min_p3_counter", b_counter, 32'd1);
    check("min_p3_capture", {31'd0, b_capture}, 32'd0);
    @(negedge clk);
    check("min_p4_capture", {31'd0, b_capture}, 32'd1);
    check("min_p4_act", {31'd0, b_act}, 32'd0);
    check("min_p4_counter", b_counter, 32'd1);
    @(negedge clk);
    check("min_p5_out_valid", {31'd0, b_out_valid}, 32'd1);
    check("min_p5_capture", {31'd0, b_capture}, 32'd0);
    @(negedge clk);
    check("min_p6_in_ready", {31'd0, b_in_ready}, 32'd1);
    check("min_p6_out_valid", {31'd0, b_out_valid}, 32'd0);
    b_out_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("sb_pending", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
